bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//   Shares one single-port BRAM (1-cycle registered read) between two requesters, A and B.
//   Each requester uses a valid/ready request channel and gets a 1-cycle-latency response channel.
//   Arbitration is round-robin. Out-of-range addresses are rejected without touching memory.
//   Sits between a compute/load engine pair and the BRAM; drives the BRAM ports directly.
// PARAMETERS
//   DataWidth  8     data word width; must match the BRAM
//   Depth      1024  number of BRAM words; legal addresses are 0..Depth-1
//   AddrWidth  $clog2(Depth)+1  address width on all address ports (localparam)
// PORTS
//   clk_i          in   1          clock; all logic on rising edge
//   rst_n_i        in   1          synchronous reset, active low
//   a_valid_i      in   1          A request valid
//   a_ready_o      out  1          A request accepted this cycle (grant)
//   a_write_i      in   1          A op: 1 = write, 0 = read
//   a_addr_i       in   AddrWidth  A word address
//   a_wdata_i      in   DataWidth  A write data
//   a_rsp_valid_o  out  1          A response valid (one cycle)
//   a_rsp_err_o    out  1          A response: address out of range
//   a_rsp_data_o   out  DataWidth  A read data (0 on writes and errors)
//   b_*            --   --         identical set of ports for requester B
//   mem_we_o       out  1          BRAM write enable
//   mem_addr_o     out  AddrWidth  BRAM address
//   mem_wdata_o    out  DataWidth  BRAM write data
//   mem_rdata_i    in   DataWidth  BRAM registered read data
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low (rst_n_i sampled on rising clk_i).
//   - Reset: last_grant = B (A wins the first tie), rsp_valid/err/data = 0 for both requesters,
//     pending response cleared. Any response in flight when reset is asserted is discarded.
//   - Grant (combinational, cycle T):
//     - Only A valid -> A. Only B valid -> B.
//     - Both valid -> the requester other than last_grant.
//     - Neither valid -> no grant.
//   - x_ready_o = grant to x. At most one ready per cycle.
//     - ready depends on valid; requesters must not make valid depend on ready.
//     - A requester must hold valid and its payload stable until ready.
//   - last_grant updates only on an accepted transfer (valid & ready).
//   - Memory drive in cycle T (combinational from the granted requester):
//     - mem_addr_o = granted address.
//     - mem_wdata_o = granted wdata.
//     - mem_we_o = write & (addr < Depth).
//     - No grant -> mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
//     - Out-of-range -> mem_we_o = 0, mem_addr_o = 0.
//   - Response: every accepted op (read or write) gives exactly one response pulse in cycle T+1
//     to the requester granted in T. The owner, op and error flag are registered at T.
//     - Read, in range: rsp_data_o = mem_rdata_i in T+1 (passthrough of the BRAM output), err = 0.
//     - Write, in range: rsp_data_o = 0, err = 0 (write ack).
//     - Out of range (addr >= Depth, incl. addr = Depth): err = 1, data = 0, memory untouched.
//   - No backpressure on responses; requesters must consume a response in its valid cycle.
//   - Back-to-back accepted ops give back-to-back responses. Throughput: 1 op/cycle total.
//   - Read-during-write to the same address in consecutive cycles: a read in T+1 after a write
//     in T returns the new data.
//   - Starvation-free: a continuously valid requester is granted within 2 cycles.
// TESTING
//   1. Reset: hold rst_n_i=0 with both valid -> no ready, no rsp_valid, mem_we_o=0; release ->
//      A granted first.
//   2. A writes 0xA5 @ 3 (T); A reads @ 3 (T+1) -> ack in T+1; a_rsp_data_o=0xA5, err=0 in T+2.
//   3. Both continuously valid for 6 cycles -> grants A,B,A,B,A,B; each response reaches only the
//      granted side, one cycle later.
//   4. B reads addr=Depth (1024) -> b_ready=1, mem_we_o=0, next cycle b_rsp_err_o=1, data=0.
//   5. B writes addr=1025 -> err=1, no memory change; a following read @ 1023 is unaffected.
//   6. Reset asserted in the cycle after an accepted read -> rsp_valid stays 0; the arbiter
//      restarts with A priority.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one single-port BRAM between requesters A and B
module bram_port_arbiter #(
  parameter  int DataWidth = 8,
  parameter  int Depth     = 1024,
  localparam int AddrWidth = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 a_valid_i,
  output logic                 a_ready_o,
  input  logic                 a_write_i,
  input  logic [AddrWidth-1:0] a_addr_i,
  input  logic [DataWidth-1:0] a_wdata_i,
  output logic                 a_rsp_valid_o,
  output logic                 a_rsp_err_o,
  output logic [DataWidth-1:0] a_rsp_data_o,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic                 b_write_i,
  input  logic [AddrWidth-1:0] b_addr_i,
  input  logic [DataWidth-1:0] b_wdata_i,
  output logic                 b_rsp_valid_o,
  output logic                 b_rsp_err_o,
  output logic [DataWidth-1:0] b_rsp_data_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);
  localparam logic [AddrWidth-1:0] DepthA = AddrWidth'(Depth);
  logic last_b_q, last_b_d, pend_q, pend_d, own_b_q, own_b_d, rd_q, rd_d, err_q, err_d;
  logic gnt_a, gnt_b, gnt, sel_write, in_range, rsp_a, rsp_b;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_wdata;
  // Grant, BRAM drive and next response bookkeeping; nothing is granted while in reset
  always_comb begin
    gnt_a = rst_n_i & a_valid_i & (~b_valid_i | last_b_q);
    gnt_b = rst_n_i & b_valid_i & (~a_valid_i | ~last_b_q);
    gnt = gnt_a | gnt_b;
    sel_write = gnt_b ? b_write_i : a_write_i;
    sel_addr = gnt_b ? b_addr_i : a_addr_i;
    sel_wdata = gnt_b ? b_wdata_i : a_wdata_i;
    in_range = sel_addr < DepthA;
    a_ready_o = gnt_a;
    b_ready_o = gnt_b;
    mem_we_o = gnt & sel_write & in_range;
    mem_addr_o = (gnt & in_range) ? sel_addr : '0;
    mem_wdata_o = gnt ? sel_wdata : '0;
    last_b_d = gnt ? gnt_b : last_b_q;
    pend_d = gnt;
    own_b_d = gnt_b;
    rd_d = gnt & ~sel_write & in_range;
    err_d = gnt & ~in_range;
  end
  // Registered owner/op/error of the op accepted last cycle; last_grant resets to B
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_b_q <= 1'b1;
      pend_q <= 1'b0;
      own_b_q <= 1'b0;
      rd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      last_b_q <= last_b_d;
      pend_q <= pend_d;
      own_b_q <= own_b_d;
      rd_q <= rd_d;
      err_q <= err_d;
    end
  end
  // Response steering; read data passes straight through from the BRAM, killed during reset
  always_comb begin
    rsp_a = rst_n_i & pend_q & ~own_b_q;
    rsp_b = rst_n_i & pend_q & own_b_q;
    a_rsp_valid_o = rsp_a;
    b_rsp_valid_o = rsp_b;
    a_rsp_err_o = rsp_a & err_q;
    b_rsp_err_o = rsp_b & err_q;
    a_rsp_data_o = (rsp_a & rd_q) ? mem_rdata_i : '0;
    b_rsp_data_o = (rsp_b & rd_q) ? mem_rdata_i : '0;
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: vector-driven check of the BRAM port arbiter against a BRAM model
module tb_bram_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_valid = 0, a_write = 0, b_valid = 0, b_write = 0;
  logic [10:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic a_ready, a_rsp_valid, a_rsp_err, b_ready, b_rsp_valid, b_rsp_err, mem_we;
  logic [7:0] a_rsp_data, b_rsp_data, mem_wdata;
  logic [10:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [1024] = '{default: 8'h00};
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // BRAM model: one-cycle registered read
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:0]];
  end

  bram_port_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_write_i(a_write), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_rsp_valid_o(a_rsp_valid), .a_rsp_err_o(a_rsp_err), .a_rsp_data_o(a_rsp_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_write_i(b_write), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_rsp_valid_o(b_rsp_valid), .b_rsp_err_o(b_rsp_err), .b_rsp_data_o(b_rsp_data),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    logic av, aw; logic [10:0] aa; logic [7:0] ad;
    logic bv, bw; logic [10:0] ba; logic [7:0] bd;
    logic rst;
    logic ear, ebr, ewe; logic [10:0] ema; logic [7:0] emw;
    logic earv, eaerr; logic [7:0] ead;
    logic ebrv, eberr; logic [7:0] ebd;
  } vec_t;
  vec_t v[$];

  task automatic add(input logic av, aw, input logic [10:0] aa, input logic [7:0] ad,
                     input logic bv, bw, input logic [10:0] ba, input logic [7:0] bd, input logic rst,
                     input logic ear, ebr, ewe, input logic [10:0] ema, input logic [7:0] emw,
                     input logic earv, eaerr, input logic [7:0] ead,
                     input logic ebrv, eberr, input logic [7:0] ebd);
    v.push_back('{av, aw, aa, ad, bv, bw, ba, bd, rst, ear, ebr, ewe, ema, emw,
                  earv, eaerr, ead, ebrv, eberr, ebd});
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(input logic av, aw, input logic [10:0] aa, input logic [7:0] ad,
                       input logic bv, bw, input logic [10:0] ba, input logic [7:0] bd, input logic rst);
    @(negedge clk);
    a_valid = av; a_write = aw; a_addr = aa; a_wdata = ad;
    b_valid = bv; b_write = bw; b_addr = ba; b_wdata = bd;
    rst_n = rst;
    #1;
  endtask

  initial begin
    // reset held with both valid
    add(1,0,5,0,     1,0,5,0,        0, 0,0,0,0,0,       0,0,0,    0,0,0);
    add(1,0,5,0,     1,0,5,0,        0, 0,0,0,0,0,       0,0,0,    0,0,0);
    // release: A wins first tie, writes A5 @3, then reads it back
    add(1,1,3,8'hA5, 1,0,7,0,        1, 1,0,1,3,8'hA5,   0,0,0,    0,0,0);
    add(1,0,3,0,     0,0,0,0,        1, 1,0,0,3,0,       1,0,0,    0,0,0);
    add(0,0,0,0,     0,0,0,0,        1, 0,0,0,0,0,       1,0,8'hA5,0,0,0);
    // B writes 3C @10 so last_grant = B
    add(0,0,0,0,     1,1,10,8'h3C,   1, 0,1,1,10,8'h3C,  0,0,0,    0,0,0);
    // both continuously valid: A,B,A,B,A,B
    add(1,0,10,0,    1,0,3,0,        1, 1,0,0,10,0,      0,0,0,    1,0,0);
    add(1,0,10,0,    1,0,3,0,        1, 0,1,0,3,0,       1,0,8'h3C,0,0,0);
    add(1,0,10,0,    1,0,3,0,        1, 1,0,0,10,0,      0,0,0,    1,0,8'hA5);
    add(1,0,10,0,    1,0,3,0,        1, 0,1,0,3,0,       1,0,8'h3C,0,0,0);
    add(1,0,10,0,    1,0,3,0,        1, 1,0,0,10,0,      0,0,0,    1,0,8'hA5);
    add(1,0,10,0,    1,0,3,0,        1, 0,1,0,3,0,       1,0,8'h3C,0,0,0);
    // B reads addr = Depth, then writes 1025, then reads aliases @1 and @1023
    add(0,0,0,0,     1,0,1024,0,     1, 0,1,0,0,0,       0,0,0,    1,0,8'hA5);
    add(0,0,0,0,     1,1,1025,8'h77, 1, 0,1,0,0,8'h77,   0,0,0,    1,1,0);
    add(0,0,0,0,     1,0,1,0,        1, 0,1,0,1,0,       0,0,0,    1,1,0);
    add(0,0,0,0,     1,0,1023,0,     1, 0,1,0,1023,0,    0,0,0,    1,0,0);
    // top legal address written and read back
    add(1,1,1023,8'h5A,0,0,0,0,      1, 1,0,1,1023,8'h5A,0,0,0,    1,0,0);
    add(1,0,1023,0,  0,0,0,0,        1, 1,0,0,1023,0,    1,0,0,    0,0,0);
    add(0,0,0,0,     0,0,0,0,        1, 0,0,0,0,0,       1,0,8'h5A,0,0,0);

    foreach (v[i]) begin
      drive(v[i].av, v[i].aw, v[i].aa, v[i].ad, v[i].bv, v[i].bw, v[i].ba, v[i].bd, v[i].rst);
      chk($sformatf("row%0d a_ready", i), a_ready, v[i].ear);
      chk($sformatf("row%0d b_ready", i), b_ready, v[i].ebr);
      chk($sformatf("row%0d mem_we", i), mem_we, v[i].ewe);
      chk($sformatf("row%0d mem_addr", i), mem_addr, v[i].ema);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata, v[i].emw);
      chk($sformatf("row%0d a_rsp_valid", i), a_rsp_valid, v[i].earv);
      chk($sformatf("row%0d a_rsp_err", i), a_rsp_err, v[i].eaerr);
      chk($sformatf("row%0d a_rsp_data", i), a_rsp_data, v[i].ead);
      chk($sformatf("row%0d b_rsp_valid", i), b_rsp_valid, v[i].ebrv);
      chk($sformatf("row%0d b_rsp_err", i), b_rsp_err, v[i].eberr);
      chk($sformatf("row%0d b_rsp_data", i), b_rsp_data, v[i].ebd);
    end

    // reset in the cycle after an accepted read discards the response and restores A priority
    drive(1,0,3,0, 0,0,0,0, 1);
    chk("rst6 accept", a_ready, 1);
    drive(1,0,3,0, 0,0,0,0, 0);
    chk("rst6 rsp killed", a_rsp_valid, 0);
    chk("rst6 ready in reset", a_ready, 0);
    drive(1,0,3,0, 1,0,7,0, 1);
    chk("rst6 A first a_ready", a_ready, 1);
    chk("rst6 A first b_ready", b_ready, 0);
    chk("rst6 no stale rsp", a_rsp_valid, 0);
    drive(0,0,0,0, 0,0,0,0, 1);
    chk("rst6 rsp valid", a_rsp_valid, 1);
    chk("rst6 rsp data", a_rsp_data, 8'hA5);
    chk("rst6 b no rsp", b_rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
